// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer.
// State encoding used by the serializer FSM.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load side.
// Back-to-back words stream with no idle gap between frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic             accept;

  assign load_ready = (state == ST_IDLE) || (bit_cnt == LAST);
  assign accept     = load_valid && load_ready;

  // Current bit always sits at the outgoing end of the register;
  // the register is cleared in IDLE so serial_out reads 0 there.
  assign serial_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      sreg         <= '0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else if (accept) begin
      state        <= ST_SHIFT;
      bit_cnt      <= '0;
      sreg         <= load_data;
      serial_valid <= 1'b1;
      frame_start  <= 1'b1;
      frame_done   <= 1'b0;
      busy         <= 1'b1;
    end else if (state == ST_SHIFT) begin
      frame_start <= 1'b0;
      if (bit_cnt == LAST) begin
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        sreg         <= '0;
        serial_valid <= 1'b0;
        frame_done   <= 1'b0;
        busy         <= 1'b0;
      end else begin
        bit_cnt    <= bit_cnt + CW'(1);
        frame_done <= (bit_cnt + CW'(1)) == LAST;
        if (MSB_FIRST)
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        else
          sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed scoreboard bench for piso_serializer, MSB- and LSB-first.
// Expected bits are queued at load time and popped each cycle.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic fs;
    logic fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid, load_valid_l;
  logic [3:0] load_data, load_data_l;

  logic m_rdy, m_so, m_sv, m_fs, m_fd, m_bz;
  logic l_rdy, l_so, l_sv, l_fs, l_fd, l_bz;

  exp_t q[$];
  exp_t lq[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (m_rdy),
    .serial_out   (m_so),
    .serial_valid (m_sv),
    .frame_start  (m_fs),
    .frame_done   (m_fd),
    .busy         (m_bz)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid_l),
    .load_data    (load_data_l),
    .load_ready   (l_rdy),
    .serial_out   (l_so),
    .serial_valid (l_sv),
    .frame_start  (l_fs),
    .frame_done   (l_fd),
    .busy         (l_bz)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input bit lsb, input logic [3:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.b  = lsb ? w[k] : w[3-k];
      e.fs = (k == 0);
      e.fd = (k == 3);
      if (lsb) lq.push_back(e);
      else     q.push_back(e);
    end
  endtask

  task automatic check_dut(input string p, input bit have,
                           input exp_t e, input logic sv,
                           input logic so, input logic fs,
                           input logic fd, input logic bz,
                           input logic rdy);
    if (have) begin
      chk({p, "_valid"}, sv, 1'b1);
      chk({p, "_sout"}, so, e.b);
      chk({p, "_fstart"}, fs, e.fs);
      chk({p, "_fdone"}, fd, e.fd);
      chk({p, "_busy"}, bz, 1'b1);
      chk({p, "_ready"}, rdy, e.fd);
    end else begin
      chk({p, "_valid_idle"}, sv, 1'b0);
      chk({p, "_sout_idle"}, so, 1'b0);
      chk({p, "_fstart_idle"}, fs, 1'b0);
      chk({p, "_fdone_idle"}, fd, 1'b0);
      chk({p, "_busy_idle"}, bz, 1'b0);
      chk({p, "_ready_idle"}, rdy, 1'b1);
    end
  endtask

  task automatic check_now();
    exp_t e;
    bit   h;
    h = (q.size() > 0);
    e = h ? q.pop_front() : '0;
    check_dut("msb", h, e, m_sv, m_so, m_fs, m_fd, m_bz, m_rdy);
    h = (lq.size() > 0);
    e = h ? lq.pop_front() : '0;
    check_dut("lsb", h, e, l_sv, l_so, l_fs, l_fd, l_bz, l_rdy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    load_valid   = 1'b0;
    load_data    = 4'h0;
    load_valid_l = 1'b0;
    load_data_l  = 4'h0;
    #2;
    check_now();
    run(2);
    @(negedge clk);
    reset_n = 1'b1;

    // single word 1011, offered right after reset release
    load_valid = 1'b1;
    load_data  = 4'b1011;
    push_word(1'b0, 4'b1011);
    run(1);
    load_valid = 1'b0;
    load_data  = 4'h7;
    run(3);
    run(2);

    // back-to-back A then 5 with load_valid held high
    load_valid = 1'b1;
    load_data  = 4'hA;
    push_word(1'b0, 4'hA);
    push_word(1'b0, 4'h5);
    run(1);
    load_data = 4'h5;
    run(4);
    load_valid = 1'b0;
    run(3);
    run(1);

    // stall: F offered while 6 is still shifting
    load_valid = 1'b1;
    load_data  = 4'h6;
    push_word(1'b0, 4'h6);
    run(1);
    load_data = 4'hF;
    push_word(1'b0, 4'hF);
    run(4);
    load_valid = 1'b0;
    run(3);
    run(1);

    // reset abort in the second bit cycle of C
    load_valid = 1'b1;
    load_data  = 4'hC;
    push_word(1'b0, 4'hC);
    run(1);
    load_valid = 1'b0;
    run(1);
    reset_n = 1'b0;
    #1;
    q.delete();
    check_now();
    run(2);
    @(negedge clk);
    reset_n    = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'h3;
    push_word(1'b0, 4'h3);
    run(1);
    load_valid = 1'b0;
    run(3);
    run(1);

    // LSB-first instance: 0001 -> 1,0,0,0
    load_valid_l = 1'b1;
    load_data_l  = 4'b0001;
    push_word(1'b1, 4'b0001);
    run(1);
    load_valid_l = 1'b0;
    load_data_l  = 4'hE;
    run(3);
    run(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width; legal values are 2 to 32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 load_valid  input  1  the parallel word on load_data is offered.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 load_ready  output  1  the block accepts a word at this edge.
REQ-009 serial_out  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial_out carries a valid bit this cycle.
REQ-011 frame_start  output  1  single-cycle pulse with the first bit of a word.
REQ-012 frame_done  output  1  single-cycle pulse with the last bit of a word.
REQ-013 busy  output  1  a word is being shifted out.

Function
REQ-014 The state machine SHALL have two states.
  - IDLE: no word in flight.
  - SHIFT: a word is being shifted out.
REQ-015 A word SHALL be accepted at a rising edge only when load_valid and load_ready are both 1.
  - The accepted word goes into the internal shift register.
  - bit_cnt is cleared to 0.
  - The state becomes SHIFT.
REQ-016 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when bit_cnt equals WIDTH-1; otherwise it is 0.
  - load_ready is decoded from registered state only.
  - load_ready does not depend on load_valid.
REQ-017 Latency SHALL be as follows.
  - A word accepted at edge N presents its first bit in the cycle after edge N.
  - Bit k of the sequence appears in cycle N+1+k, for k = 0 to WIDTH-1.
REQ-018 serial_out, serial_valid, frame_start and frame_done SHALL be driven from registers; there is no combinational path from the inputs.
REQ-019 In SHIFT, serial_valid SHALL be 1 and serial_out SHALL equal the current bit.
  - MSB_FIRST=1: the shift register shifts left.
  - MSB_FIRST=0: the shift register shifts right.
REQ-020 frame_start SHALL be 1 exactly when bit_cnt equals 0 in SHIFT.
REQ-021 frame_done SHALL be 1 exactly when bit_cnt equals WIDTH-1 in SHIFT.
REQ-022 A word accepted during the last-bit cycle SHALL start in the next cycle with no idle gap.
  - bit_cnt reloads to 0 and the state stays SHIFT.
  - frame_done and the next frame_start fall on consecutive cycles.
REQ-023 If no word is accepted in the last-bit cycle, the state SHALL return to IDLE.
  - In IDLE, serial_out, serial_valid, frame_start and frame_done are 0.
REQ-024 load_data SHALL be ignored whenever load_valid and load_ready are not both 1; a word in flight is never corrupted.
REQ-025 busy SHALL be 1 in SHIFT and 0 in IDLE.
REQ-026 bit_cnt SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-027 When reset_n is 0, the block SHALL immediately force the following, regardless of clk.
  - State IDLE, bit_cnt 0, shift register 0.
  - serial_out 0, serial_valid 0, frame_start 0, frame_done 0, busy 0.
REQ-028 A reset during SHIFT SHALL abort the word; no frame_done is produced for it.
REQ-029 load_ready SHALL be 1 during reset; the first word can be accepted at the first edge after reset_n rises.

Structure
REQ-030 The shared package piso_pkg SHALL hold the state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1.
REQ-031 The block SHALL be a single module with no sub-module; the bit counter and shift register are inline.

Verification
REQ-032 The bench SHALL cover the following directed scenarios.
  - Reset: assert reset_n=0 mid-stream -> all outputs 0 at once; load_ready=1.
  - Single word, WIDTH=4, MSB_FIRST=1, load 4'b1011 at edge N:
    - serial_out is 1,0,1,1 in cycles N+1 to N+4 with serial_valid=1.
    - frame_start=1 in cycle N+1 and frame_done=1 in cycle N+4.
    - load_ready=0 in cycles N+1 to N+3.
  - Back-to-back: hold load_valid=1 with 4'hA then 4'h5:
    - eight consecutive valid bits 1,0,1,0,0,1,0,1 with no gap.
    - frame_done pulses twice; busy stays 1 throughout.
  - Stall: offer 4'hF in cycles N+1 to N+3 while 4'h6 is shifting:
    - no acceptance until the last-bit cycle N+4.
    - 1,1,1,1 follows 0,1,1,0 seamlessly.
  - Reset abort: pull reset_n low in cycle N+2 of 4'hC:
    - outputs 0 at once, no frame_done.
    - after release, 4'h3 is sent cleanly as 0,0,1,1.
  - LSB-first, MSB_FIRST=0: load 4'b0001 -> serial_out is 1,0,0,0.
